// File: rtl/cpu_mem_responder_pkg.sv
// Shared constants for the CPU memory responder: widths, CPU access codes,
// loader state encoding and load-target select values.
package cpu_mem_responder_pkg;

  localparam int WIDTH    = 32;
  localparam int ADDRSIZE = 12;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic LD_IMEM = 1'b0;
  localparam logic LD_DMEM = 1'b1;

endpackage

// File: rtl/cpu_mem_responder_mem_array.sv
// Word-addressed storage with one synchronous write port and one
// combinational read port; contents are never cleared by reset.
module mem_array #(
  parameter int ADDRSIZE = 12,
  parameter int WIDTH    = 32
) (
  input  logic                clk,
  input  logic                we,
  input  logic [ADDRSIZE-1:0] waddr,
  input  logic [0:WIDTH-1]    wdata,
  input  logic [ADDRSIZE-1:0] raddr,
  output logic [0:WIDTH-1]    rdata
);

  logic [0:WIDTH-1] mem [0:(1<<ADDRSIZE)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/cpu_mem_responder.sv
// CPU data/instruction memory responder with a byte-serial program loader
// that holds the CPU in reset while it fills either memory.
module cpu_mem_responder #(
  parameter int WIDTH    = cpu_mem_responder_pkg::WIDTH,
  parameter int ADDRSIZE = cpu_mem_responder_pkg::ADDRSIZE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDRSIZE-1:0] MEM_ADDR,
  input  logic [0:WIDTH-1]    MEM_OUT,
  input  logic                MEM_CTRL,
  output logic [0:WIDTH-1]    MEM_IN,
  input  logic [ADDRSIZE-1:0] INS_ADDR,
  output logic [0:WIDTH-1]    INS_MEM,
  input  logic                ld_start,
  input  logic                ld_sel,
  input  logic                ld_valid,
  input  logic [7:0]          ld_byte,
  input  logic                ld_last,
  output logic                ld_ready,
  output logic                ld_done,
  output logic                ld_err,
  output logic                cpu_rst
);

  import cpu_mem_responder_pkg::*;

  localparam int BYTES  = WIDTH / 8;
  localparam int BIDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [1:0]          state;
  logic                sel;
  logic [ADDRSIZE-1:0] addr;
  logic [BIDX_W-1:0]   bidx;
  logic [0:WIDTH-1]    shreg;
  logic [0:WIDTH-1]    word_next;
  logic                accept;
  logic                full;
  logic                word_wr;

  logic                imem_we;
  logic                dmem_we;
  logic [ADDRSIZE-1:0] dmem_waddr;
  logic [0:WIDTH-1]    dmem_wdata;

  assign ld_ready = (state == LOAD);
  assign ld_done  = (state == DONE);
  assign accept   = (state == LOAD) && ld_valid;
  assign full     = (bidx == BIDX_W'(BYTES - 1));
  assign word_wr  = accept && (full || ld_last);

  // shreg holds zeros in unfilled byte lanes, so a word cut short by
  // ld_last is written with its low-order bytes cleared.
  always_comb begin
    word_next = shreg;
    word_next[int'(bidx)*8 +: 8] = ld_byte;
  end

  assign imem_we = word_wr && (sel == LD_IMEM);

  always_comb begin
    dmem_we    = 1'b0;
    dmem_waddr = MEM_ADDR;
    dmem_wdata = MEM_OUT;
    if (state == LOAD) begin
      dmem_we    = word_wr && (sel == LD_DMEM);
      dmem_waddr = addr;
      dmem_wdata = word_next;
    end else if (state == IDLE) begin
      dmem_we    = (MEM_CTRL == MEM_WRITE);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      sel     <= LD_IMEM;
      addr    <= '0;
      bidx    <= '0;
      shreg   <= '0;
      cpu_rst <= 1'b1;
      ld_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ld_start) begin
            state   <= LOAD;
            sel     <= ld_sel;
            addr    <= '0;
            bidx    <= '0;
            shreg   <= '0;
            cpu_rst <= 1'b1;
            ld_err  <= 1'b0;
          end
        end
        LOAD: begin
          if (accept) begin
            if (word_wr) begin
              shreg <= '0;
              bidx  <= '0;
              if (full) begin
                addr <= addr + ADDRSIZE'(1);
                if (addr == '1) begin
                  ld_err <= 1'b1;
                end
              end
            end else begin
              shreg <= word_next;
              bidx  <= bidx + BIDX_W'(1);
            end
            if (ld_last) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          state   <= IDLE;
          cpu_rst <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  mem_array #(
    .ADDRSIZE(ADDRSIZE),
    .WIDTH   (WIDTH)
  ) u_imem (
    .clk  (clk),
    .we   (imem_we),
    .waddr(addr),
    .wdata(word_next),
    .raddr(INS_ADDR),
    .rdata(INS_MEM)
  );

  mem_array #(
    .ADDRSIZE(ADDRSIZE),
    .WIDTH   (WIDTH)
  ) u_dmem (
    .clk  (clk),
    .we   (dmem_we),
    .waddr(dmem_waddr),
    .wdata(dmem_wdata),
    .raddr(MEM_ADDR),
    .rdata(MEM_IN)
  );

endmodule
